vending_transaction_controller: RTL and testbench
=================================================

Name: vending_transaction_controller

Overview:
- Top-level sequencer for the vending machine datapath.
- Accumulates inserted coins into a running total and evaluates item purchases against per-item prices.
- Runs the inactivity timeout and schedules change return as a one-coin-per-cycle greedy drain of the total.
- Sits between the coin/button front end and the dispense/return actuators; it owns total, timer and transaction state.

Parameters:
- NUM_COINS, 3, number of coin denominations; bit i of coin buses = denomination i.
- NUM_ITEMS, 4, number of items; bit k of item buses = item k.
- COIN_VAL0 / COIN_VAL1 / COIN_VAL2, 100 / 500 / 1000, coin values, ascending.
- ITEM_PRICE0..3, 400 / 500 / 1000 / 2000, item prices; all are multiples of COIN_VAL0.
- MAX_TOTAL, 9900, highest total the machine holds.
- WAIT_CYCLES, 10, inactivity timeout reload value.
- TOTAL_W, 16, width of the total register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_input_coin  in  NUM_COINS  one pulse per inserted coin; multiple bits in one cycle = multiple coins.
- i_select_item  in  NUM_ITEMS  purchase request; must be one-hot.
- i_trigger_return  in  1  user return request.
- o_available_item  out  NUM_ITEMS  bit k=1 when total >= ITEM_PRICEk.
- o_output_item  out  NUM_ITEMS  one-cycle dispense pulse, registered.
- o_return_coin  out  NUM_COINS  one-hot return pulse, at most one bit per cycle, registered.
- o_reject_coin  out  NUM_COINS  echo of refused coins, registered, one cycle.
- o_current_total  out  TOTAL_W  running total.
- o_wait_time  out  32  remaining timeout cycles.
- o_returning  out  1  high while in RETURN.

Behaviour:
- States: IDLE (total=0), ACCEPT (total>0), RETURN.
- Reset (sampled at clk edge): state IDLE; total, wait_time and all outputs 0. Reset applied mid-RETURN aborts the drain, and no further coins are emitted.
- Coin accept (IDLE/ACCEPT):
  - Sum of asserted coin values is added at the next edge.
  - If total + sum - purchase > MAX_TOTAL, all coins of that cycle are refused: mirrored on o_reject_coin next cycle, total unchanged.
  - Accepted coins move IDLE->ACCEPT and reload wait_time to WAIT_CYCLES.
- Purchase (ACCEPT):
  - Valid when i_select_item is one-hot and the pre-edge total >= price.
  - Next edge: total -= price, o_output_item = i_select_item for one cycle, wait_time reloaded.
  - Multi-hot, zero, or insufficient-funds selects are ignored with no output.
  - Coin and valid purchase in the same cycle: next total = total + coins - price.
  - If the result is 0: state IDLE, wait_time 0.
- Timer:
  - In ACCEPT without a reload event, wait_time decrements by 1 per cycle, saturating at 0.
  - The edge where wait_time goes 1->0 also enters RETURN.
  - In IDLE/RETURN, wait_time holds 0.
- Return entry:
  - i_trigger_return in ACCEPT -> RETURN at the next edge; it has priority over coin/select in the same cycle, and those coins are rejected.
  - Trigger in IDLE is ignored.
- RETURN drain:
  - Each edge: o_return_coin = one-hot of the largest denomination <= total, and total -= that value.
  - The edge making total 0 also moves to IDLE.
  - No idle cycles between coins.
  - Coins are rejected via o_reject_coin; selects and triggers are ignored.
- Output timing:
  - o_available_item is combinational from the registered total and is forced to 0 in RETURN.
  - o_output_item, o_return_coin and o_reject_coin are 0 in every cycle they are not pulsing.
- Arithmetic: unsigned; total never underflows, since a purchase requires total >= price.

Test Plan:
- Reset, insert 1000 then 500 on consecutive cycles -> o_current_total=1500, o_available_item=0111, wait_time=10.
- From 1500, select 0010 -> o_output_item=0010 for one cycle, total 1000, wait_time reloaded to 10. Then select 1000 -> ignored, no pulse, total 1000.
- From total 1600, pulse i_trigger_return -> o_return_coin 100, 010, 001 on three consecutive cycles, total 0, IDLE, o_returning falls.
- Insert 100, then no activity -> wait_time counts 10 down to 0, then o_return_coin=001 once, total 0.
- Coin 1000 during RETURN -> o_reject_coin=100 next cycle, drain sequence unchanged. Total 9500 + coin 1000 -> rejected, total stays 9500.
- Assert reset midway through draining 1600 -> total, outputs and state are zero/IDLE on the next edge, and no further return pulses.

Source files
------------

// File: rtl/vending_transaction_controller_if.sv
// Coin/button front-end and actuator bundle for the vending transaction controller.
// The slave side is the controller; the master side is the front end (or a bench).
interface vending_transaction_controller_if #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter int TOTAL_W   = 16
);
    logic [NUM_COINS-1:0] i_input_coin;
    logic [NUM_ITEMS-1:0] i_select_item;
    logic                 i_trigger_return;
    logic [NUM_ITEMS-1:0] o_available_item;
    logic [NUM_ITEMS-1:0] o_output_item;
    logic [NUM_COINS-1:0] o_return_coin;
    logic [NUM_COINS-1:0] o_reject_coin;
    logic [TOTAL_W-1:0]   o_current_total;
    logic [31:0]          o_wait_time;
    logic                 o_returning;

    modport master (
        output i_input_coin, i_select_item, i_trigger_return,
        input  o_available_item, o_output_item, o_return_coin, o_reject_coin,
               o_current_total, o_wait_time, o_returning
    );

    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return,
        output o_available_item, o_output_item, o_return_coin, o_reject_coin,
               o_current_total, o_wait_time, o_returning
    );
endinterface

// File: rtl/vending_transaction_controller.sv
// Vending machine transaction sequencer: owns the running total, the inactivity
// timer and the IDLE/ACCEPT/RETURN state. Change is paid back greedily, one coin
// per cycle, largest denomination that still fits the remaining total.
module vending_transaction_controller #(
    parameter int NUM_COINS   = 3,
    parameter int NUM_ITEMS   = 4,
    parameter int COIN_VAL0   = 100,
    parameter int COIN_VAL1   = 500,
    parameter int COIN_VAL2   = 1000,
    parameter int ITEM_PRICE0 = 400,
    parameter int ITEM_PRICE1 = 500,
    parameter int ITEM_PRICE2 = 1000,
    parameter int ITEM_PRICE3 = 2000,
    parameter int MAX_TOTAL   = 9900,
    parameter int WAIT_CYCLES = 10,
    parameter int TOTAL_W     = 16
) (
    input  logic clk,
    input  logic reset,
    vending_transaction_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic [31:0]          waitTime_q, waitTime_d;
    logic [NUM_ITEMS-1:0] outputItem_q, outputItem_d;
    logic [NUM_COINS-1:0] returnCoin_q, returnCoin_d;
    logic [NUM_COINS-1:0] rejectCoin_q, rejectCoin_d;

    logic [31:0]          totalWide;
    logic [31:0]          coinSum;
    logic [31:0]          selPrice;
    logic                 purchaseValid;
    logic [NUM_COINS-1:0] drainCoin;
    logic [31:0]          drainValue;
    logic [31:0]          afterPurchase;
    logic [31:0]          candidate;
    logic                 coinsAccepted;
    logic [NUM_ITEMS-1:0] availItem;

    function automatic logic [31:0] coinValue(input int idx);
        case (idx)
            0:       return 32'(COIN_VAL0);
            1:       return 32'(COIN_VAL1);
            default: return 32'(COIN_VAL2);
        endcase
    endfunction

    function automatic logic [31:0] itemPrice(input int idx);
        case (idx)
            0:       return 32'(ITEM_PRICE0);
            1:       return 32'(ITEM_PRICE1);
            2:       return 32'(ITEM_PRICE2);
            default: return 32'(ITEM_PRICE3);
        endcase
    endfunction

    assign totalWide = 32'(total_q);

    // Value of all coins dropped this cycle; several bits at once mean several coins.
    always_comb begin
        coinSum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (bus.i_input_coin[i]) coinSum = coinSum + coinValue(i);
        end
    end

    // Price of the requested item; only meaningful when the request is one-hot,
    // so a purchase is only honoured in ACCEPT with enough credit.
    always_comb begin
        selPrice = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (bus.i_select_item[k]) selPrice = itemPrice(k);
        end
        purchaseValid = (state_q == ACCEPT) && $onehot(bus.i_select_item)
                        && (totalWide >= selPrice);
    end

    // Largest denomination not exceeding the remaining total; denominations are
    // ascending so the last match wins. A zero value means nothing can be paid.
    always_comb begin
        drainCoin  = '0;
        drainValue = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (totalWide >= coinValue(i)) begin
                drainCoin     = '0;
                drainCoin[i]  = 1'b1;
                drainValue    = coinValue(i);
            end
        end
    end

    // Next-state and next-output logic. A return request beats coins and selects;
    // coins that would push the total past the cap are echoed back untouched.
    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        waitTime_d    = waitTime_q;
        outputItem_d  = '0;
        returnCoin_d  = '0;
        rejectCoin_d  = '0;
        afterPurchase = totalWide;
        candidate     = totalWide;
        coinsAccepted = 1'b0;
        case (state_q)
            IDLE, ACCEPT: begin
                if ((state_q == ACCEPT) && bus.i_trigger_return) begin
                    state_d      = RETURN;
                    waitTime_d   = '0;
                    rejectCoin_d = bus.i_input_coin;
                end else begin
                    afterPurchase = totalWide - (purchaseValid ? selPrice : 32'd0);
                    candidate     = afterPurchase + coinSum;
                    coinsAccepted = (|bus.i_input_coin) && (candidate <= 32'(MAX_TOTAL));
                    if ((|bus.i_input_coin) && !coinsAccepted) begin
                        rejectCoin_d = bus.i_input_coin;
                        candidate    = afterPurchase;
                    end
                    if (purchaseValid) outputItem_d = bus.i_select_item;
                    total_d = TOTAL_W'(candidate);
                    if (candidate == 32'd0) begin
                        state_d    = IDLE;
                        waitTime_d = '0;
                    end else if (coinsAccepted || purchaseValid) begin
                        state_d    = ACCEPT;
                        waitTime_d = 32'(WAIT_CYCLES);
                    end else if (waitTime_q > 32'd1) begin
                        state_d    = ACCEPT;
                        waitTime_d = waitTime_q - 32'd1;
                    end else begin
                        state_d    = RETURN;
                        waitTime_d = '0;
                    end
                end
            end
            RETURN: begin
                rejectCoin_d = bus.i_input_coin;
                waitTime_d   = '0;
                if (drainValue == 32'd0) begin
                    total_d = '0;
                    state_d = IDLE;
                end else begin
                    returnCoin_d = drainCoin;
                    total_d      = TOTAL_W'(totalWide - drainValue);
                    if (totalWide == drainValue) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                total_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any drain in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            total_q      <= '0;
            waitTime_q   <= '0;
            outputItem_q <= '0;
            returnCoin_q <= '0;
            rejectCoin_q <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            waitTime_q   <= waitTime_d;
            outputItem_q <= outputItem_d;
            returnCoin_q <= returnCoin_d;
            rejectCoin_q <= rejectCoin_d;
        end
    end

    // Affordable-item lamps follow the registered total, dark while paying change.
    always_comb begin
        availItem = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            availItem[k] = (state_q != RETURN) && (totalWide >= itemPrice(k));
        end
    end

    assign bus.o_available_item = availItem;
    assign bus.o_output_item    = outputItem_q;
    assign bus.o_return_coin    = returnCoin_q;
    assign bus.o_reject_coin    = rejectCoin_q;
    assign bus.o_current_total  = total_q;
    assign bus.o_wait_time      = waitTime_q;
    assign bus.o_returning      = (state_q == RETURN);

endmodule

// File: tb/tb_vending_transaction_controller.sv
// Scoreboard bench for the vending transaction controller: each cycle's expected
// outputs are queued with the stimulus and compared against what the DUT showed.
module tb_vending_transaction_controller;

    typedef struct packed {
        logic [15:0] total;
        logic [31:0] waitTime;
        logic [3:0]  outItem;
        logic [2:0]  retCoin;
        logic [2:0]  reject;
        logic        returning;
        logic [3:0]  avail;
    } obs_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t expQ[$];
    obs_t obsQ[$];

    vending_transaction_controller_if #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_W(16)) busIf ();

    vending_transaction_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected snapshot; lamps derive from the item prices 400/500/1000/2000.
    function automatic obs_t mk(input int total, input int waitT, input logic [3:0] outItem,
                                input logic [2:0] retCoin, input logic [2:0] rej, input logic rtn);
        obs_t v;
        v.total     = 16'(total);
        v.waitTime  = 32'(waitT);
        v.outItem   = outItem;
        v.retCoin   = retCoin;
        v.reject    = rej;
        v.returning = rtn;
        v.avail     = rtn ? 4'b0000 : {total >= 2000, total >= 1000, total >= 500, total >= 400};
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t v;
        v.total     = busIf.o_current_total;
        v.waitTime  = busIf.o_wait_time;
        v.outItem   = busIf.o_output_item;
        v.retCoin   = busIf.o_return_coin;
        v.reject    = busIf.o_reject_coin;
        v.returning = busIf.o_returning;
        v.avail     = busIf.o_available_item;
        return v;
    endfunction

    function automatic string fmt(input obs_t v);
        return $sformatf("total=%0d wait=%0d out=%b ret=%b rej=%b rtn=%b av=%b",
                         v.total, v.waitTime, v.outItem, v.retCoin, v.reject, v.returning, v.avail);
    endfunction

    // One clock of stimulus: queue what should appear after the edge, then record what did.
    task automatic drive(input logic [2:0] coin, input logic [3:0] sel, input logic trig,
                         input logic rst, input obs_t e);
        busIf.i_input_coin     = coin;
        busIf.i_select_item    = sel;
        busIf.i_trigger_return = trig;
        reset                  = rst;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        obsQ.push_back(sample());
        #1;
        busIf.i_input_coin     = '0;
        busIf.i_select_item    = '0;
        busIf.i_trigger_return = 1'b0;
        reset                  = 1'b0;
    endtask

    // Reset wins over coins, selects and triggers presented at the same edge.
    task automatic test_reset();
        obs_t e, o;
        int n = 0;
        drive(3'b111, 4'b0001, 1'b1, 1'b1, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b111, 4'b0100, 1'b1, 1'b1, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Coins accumulate and reload the timer; idle cycles count it down.
    task automatic test_coin_accept();
        obs_t e, o;
        int n = 0;
        drive(3'b100, 4'b0, 1'b0, 1'b0, mk(1000, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b010, 4'b0, 1'b0, 1'b0, mk(1500, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(1500, 9, 4'b0, 3'b0, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL coin_accept step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Valid, unaffordable, multi-hot and idle-state purchases, plus coin+buy together.
    task automatic test_purchase();
        obs_t e, o;
        int n = 0;
        drive(3'b000, 4'b0010, 1'b0, 1'b0, mk(1000, 10, 4'b0010, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b1000, 1'b0, 1'b0, mk(1000, 9, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0011, 1'b0, 1'b0, mk(1000, 8, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0000, 1'b0, 1'b0, mk(1000, 7, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0100, 1'b0, 1'b0, mk(0, 0, 4'b0100, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0000, 1'b1, 1'b0, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0001, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b010, 4'b0000, 1'b0, 1'b0, mk(500, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b001, 4'b0001, 1'b0, 1'b0, mk(200, 10, 4'b0001, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0000, 1'b1, 1'b0, mk(200, 0, 4'b0, 3'b0, 3'b0, 1'b1));
        drive(3'b000, 4'b0000, 1'b0, 1'b0, mk(100, 0, 4'b0, 3'b001, 3'b0, 1'b1));
        drive(3'b000, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b001, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL purchase step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Return of 1600 as 1000/500/100; coins during trigger or drain are refused.
    task automatic test_return();
        obs_t e, o;
        int n = 0;
        drive(3'b100, 4'b0, 1'b0, 1'b0, mk(1000, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b010, 4'b0, 1'b0, 1'b0, mk(1500, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(1600, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b001, 4'b0, 1'b1, 1'b0, mk(1600, 0, 4'b0, 3'b0, 3'b001, 1'b1));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(600, 0, 4'b0, 3'b100, 3'b0, 1'b1));
        drive(3'b100, 4'b0001, 1'b1, 1'b0, mk(100, 0, 4'b0, 3'b010, 3'b100, 1'b1));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b001, 3'b0, 1'b0));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL return step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Inactivity: timer runs 10 -> 0, enters RETURN, then pays back the 100.
    task automatic test_timeout();
        obs_t e, o;
        int n = 0;
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(100, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        for (int w = 9; w >= 1; w--) begin
            drive(3'b000, 4'b0, 1'b0, 1'b0, mk(100, w, 4'b0, 3'b0, 3'b0, 1'b0));
        end
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(100, 0, 4'b0, 3'b0, 3'b0, 1'b1));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b001, 3'b0, 1'b0));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL timeout step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Cap at 9900: exact fill accepted, overflow refused, coin+buy netting under cap accepted.
    task automatic test_overflow();
        obs_t e, o;
        int n = 0;
        for (int c = 1; c <= 5; c++) begin
            drive(3'b111, 4'b0, 1'b0, 1'b0, mk(1600 * c, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        end
        drive(3'b110, 4'b0, 1'b0, 1'b0, mk(9500, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b100, 4'b0, 1'b0, 1'b0, mk(9500, 9, 4'b0, 3'b0, 3'b100, 1'b0));
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(9600, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b010, 4'b0, 1'b0, 1'b0, mk(9600, 9, 4'b0, 3'b0, 3'b010, 1'b0));
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(9700, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(9800, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(9900, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b001, 4'b0, 1'b0, 1'b0, mk(9900, 9, 4'b0, 3'b0, 3'b001, 1'b0));
        drive(3'b100, 4'b1000, 1'b0, 1'b0, mk(8900, 10, 4'b1000, 3'b0, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL overflow step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Long gap-free drain of 8900: greedy change 8x1000, 1x500, 4x100.
    task automatic test_back_to_back();
        obs_t e, o;
        int n = 0;
        int t = 8900;
        logic [2:0] c;
        drive(3'b000, 4'b0, 1'b1, 1'b0, mk(8900, 0, 4'b0, 3'b0, 3'b0, 1'b1));
        while (t > 0) begin
            if (t >= 1000) begin c = 3'b100; t = t - 1000; end
            else if (t >= 500) begin c = 3'b010; t = t - 500; end
            else begin c = 3'b001; t = t - 100; end
            drive(3'b000, 4'b0, 1'b0, 1'b0, mk(t, 0, 4'b0, c, 3'b0, t != 0));
        end
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Reset in the middle of a drain clears everything and stops further coins.
    task automatic test_reset_midreturn();
        obs_t e, o;
        int n = 0;
        drive(3'b111, 4'b0, 1'b0, 1'b0, mk(1600, 10, 4'b0, 3'b0, 3'b0, 1'b0));
        drive(3'b000, 4'b0, 1'b1, 1'b0, mk(1600, 0, 4'b0, 3'b0, 3'b0, 1'b1));
        drive(3'b000, 4'b0, 1'b0, 1'b0, mk(600, 0, 4'b0, 3'b100, 3'b0, 1'b1));
        drive(3'b000, 4'b0, 1'b0, 1'b1, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 4'b0, 1'b0, 1'b0, mk(0, 0, 4'b0, 3'b0, 3'b0, 1'b0));
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); checks++; n++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_midreturn step %0d: got %s, want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    // Scenario sequence; each scenario leaves the machine idle with zero total.
    initial begin
        reset                  = 1'b1;
        busIf.i_input_coin     = '0;
        busIf.i_select_item    = '0;
        busIf.i_trigger_return = 1'b0;
        #3;
        test_reset();
        test_coin_accept();
        test_purchase();
        test_return();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_reset_midreturn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
